// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline stall/flush controls
//   master: pipeline side, drives ID/EX fields, receives controls
//   slave : hazard_ctrl side
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             EX_memread;
    logic [4:0]       EX_Rt;
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_uses_rt;
    logic             ID_branch_taken;
    logic             ID_md_start;
    logic             PC_write;
    logic             IF_ID_write;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             md_busy;
    logic [CNT_W-1:0] stall_count;
    modport master (
        output EX_memread, EX_Rt, ID_Rs, ID_Rt, ID_uses_rt, ID_branch_taken, ID_md_start,
        input  PC_write, IF_ID_write, flush_IF_ID, flush_ID_EX, md_busy, stall_count
    );
    modport slave (
        input  EX_memread, EX_Rt, ID_Rs, ID_Rt, ID_uses_rt, ID_branch_taken, ID_md_start,
        output PC_write, IF_ID_write, flush_IF_ID, flush_ID_EX, md_busy, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for load-use, taken branch and mult/div occupancy
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_ctrl_if.slave (ID/EX fields in, PC/IF_ID/ID_EX controls out,
//              registered md_busy and saturating stall_count out)
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    localparam int MD_W = $clog2(MD_LATENCY);
    typedef enum logic {IDLE, MD_BUSY} state_t;
    state_t           r_state;
    logic [MD_W-1:0]  r_md_cnt;
    logic             r_md_busy;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_lu;
    logic             w_busy;
    logic             w_hold;
    assign w_lu   = bus.EX_memread && (bus.EX_Rt != 5'd0) &&
                    ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_uses_rt && bus.EX_Rt == bus.ID_Rt));
    assign w_busy = (r_state == MD_BUSY);
    // hold the front end: mult/div occupying EX, or a load-use bubble
    assign w_hold = w_busy || w_lu;
    assign bus.PC_write    = !rst && !w_hold;
    assign bus.IF_ID_write = !rst && !w_hold;
    assign bus.flush_IF_ID = rst || (!w_hold && bus.ID_branch_taken);
    assign bus.flush_ID_EX = rst || w_hold;
    assign bus.md_busy     = r_md_busy;
    assign bus.stall_count = r_stall_count;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_md_cnt      <= '0;
            r_md_busy     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            if (!bus.PC_write && r_stall_count != '1)
                r_stall_count <= r_stall_count + CNT_W'(1);
            case (r_state)
                IDLE: if (!w_lu && bus.ID_md_start) begin
                    // the op enters EX this cycle; MD_LATENCY-1 further cycles remain
                    r_state   <= MD_BUSY;
                    r_md_cnt  <= MD_W'(MD_LATENCY - 2);
                    r_md_busy <= 1'b1;
                end
                default: if (r_md_cnt == '0) begin
                    r_state   <= IDLE;
                    r_md_busy <= 1'b0;
                end else begin
                    r_md_cnt <= r_md_cnt - MD_W'(1);
                end
            endcase
        end
    end
endmodule
